// File: rtl/arf_multiport_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arf_multiport_if : read/write/clear port bundle for arf_multiport
// Rev 1.0
// ---------------------------------------------------------------------------
interface arf_multiport_if #(
  parameter int AR_SIZE = 6,
  parameter int DATA_W  = 32,
  parameter int NUM_RD  = 4,
  parameter int NUM_WR  = 2
);
  logic                       clear_req;
  logic                       ready;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*AR_SIZE-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*AR_SIZE-1:0]  wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;

  modport master (
    output clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  ready, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output ready, rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/arf_multiport.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arf_multiport : multi-port architectural register file, sweep-cleared
// Rev 1.0
// ---------------------------------------------------------------------------
module arf_multiport #(
  parameter int AR_SIZE  = 6,
  parameter int AR_ARRAY = 64,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  arf_multiport_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AR_SIZE:0]   c_DEPTH = (AR_SIZE+1)'(AR_ARRAY);
  localparam logic [AR_SIZE-1:0] c_LAST  = AR_SIZE'(AR_ARRAY - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AR_SIZE-1:0] r_cnt;
  logic [AR_SIZE-1:0] w_cnt_nxt;
  logic               w_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_run     = (r_state == ST_RUN);
  assign bus.ready = w_run;

  // Entry 0 is hardwired to zero, so writes to it are squashed here.
  logic [NUM_WR-1:0]  w_wr_ok;
  logic [AR_SIZE-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0]  w_wr_data [NUM_WR];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign w_wr_addr[j] = bus.wr_addr[j*AR_SIZE +: AR_SIZE];
    assign w_wr_data[j] = bus.wr_data[j*DATA_W +: DATA_W];
    assign w_wr_ok[j]   = w_run && bus.wr_en[j] && (w_wr_addr[j] != '0)
                          && ({1'b0, w_wr_addr[j]} < c_DEPTH);
  end

  logic [DATA_W-1:0] r_mem [AR_ARRAY];

  // Ascending loop: the last non-blocking write wins, giving the highest port priority.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  logic [AR_SIZE-1:0] w_rd_addr [NUM_RD];
  logic [NUM_RD-1:0]  w_rd_ok;
  logic [DATA_W-1:0]  w_rd_val  [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign w_rd_addr[i] = bus.rd_addr[i*AR_SIZE +: AR_SIZE];
    assign w_rd_ok[i]   = (w_rd_addr[i] != '0) && ({1'b0, w_rd_addr[i]} < c_DEPTH);
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_val[i] = '0;
      if (w_rd_ok[i]) begin
        w_rd_val[i] = r_mem[w_rd_addr[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_ok[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
              w_rd_val[i] = w_wr_data[j];
            end
          end
        end
      end
    end
  end

  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        r_rd_valid[i] <= w_run && bus.rd_en[i];
        if (w_run && bus.rd_en[i]) begin
          r_rd_data[i*DATA_W +: DATA_W] <= w_rd_val[i];
        end
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/arf_multiport.md
# arf_multiport

Parametrised architectural register file for the out-of-order core's retire stage. It has NUM_RD registered read ports, NUM_WR retire write ports with per-port enables, and deterministic priority when write addresses collide. An optional same-cycle write-to-read bypass is selected by parameter. Instead of a single-cycle array reset, a sequential clear-sweep FSM zeroes the array after reset or on request, and a `ready` flag gates all traffic while the sweep runs.

## Interface
- AR_SIZE, 6: address width.
- AR_ARRAY, 64: number of entries. Must satisfy 2 ≤ AR_ARRAY ≤ 2^AR_SIZE.
- DATA_W, 32: entry width.
- NUM_RD, 4: read ports.
- NUM_WR, 2: write (retire) ports.
- BYPASS, 1: 1 means a read returns same-cycle write data; 0 means a read returns the pre-write value.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  one-cycle request to re-zero the whole array.
- ready  out  1  high when the array is usable; low during the sweep.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*AR_SIZE  port i occupies bits [i*AR_SIZE +: AR_SIZE].
- rd_data  out  NUM_RD*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- rd_valid  out  NUM_RD  one-cycle pulse marking new rd_data for port i.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AR_SIZE  packed like rd_addr.
- wr_data  in  NUM_WR*DATA_W  packed like rd_data.

## Operation
- FSM states:
  - INIT: sweep in progress; ready=0.
  - RUN: ready=1.
- rst → INIT with sweep counter cnt=0.
- In INIT, each cycle writes 0 to entry cnt, then cnt increments. In the cycle that clears entry AR_ARRAY-1, the next state is RUN.
- While in INIT:
  - rd_en and wr_en are ignored; rd_valid stays 0.
  - clear_req is ignored; the sweep does not restart.
- RUN with clear_req=1:
  - That cycle's reads and writes are still performed.
  - The FSM enters INIT with cnt=0 on the next cycle.
- Writes (RUN only):
  - wr_en[j] writes wr_data[j] to wr_addr[j].
  - Address 0 is never written; entry 0 always reads 0.
  - Addresses ≥ AR_ARRAY are dropped.
  - If several enabled ports target the same address, the highest-index port wins.
- Reads (RUN only):
  - rd_en[i] is sampled, rd_data[i] is registered, and rd_valid[i]=1 on the next cycle.
  - Address 0 and addresses ≥ AR_ARRAY return 0.
- Bypass (BYPASS=1): if an enabled write in the same cycle targets the read address (nonzero, in range), rd_data[i] takes that write's data. Highest-index matching write port wins. With BYPASS=0, the old array value is returned.
- rd_data[i] holds its last value when there is no read on port i. rd_valid[i] drops to 0.
- Any number of read ports may hit the same address in the same cycle.

## Timing
- Reset values:
  - ready=0, rd_valid=0, rd_data=0, state=INIT, cnt=0.
  - Array contents are undefined until the sweep completes.
- Sweep length is exactly AR_ARRAY cycles. With rst deasserted before edge 0, ready=1 after edge AR_ARRAY-1 (default: 64 cycles).
- rst asserted mid-sweep or in RUN: the next edge returns to INIT with cnt=0 and clears rd_valid and rd_data.
- Read latency is 1 cycle: inputs sampled at edge N, rd_data/rd_valid visible after edge N.
- A write sampled at edge N is visible to a non-bypassed read sampled at edge N+1.
- ready falls the cycle after a RUN-state clear_req. The first request cycle still reports ready=1.
- cnt is AR_SIZE bits wide and never wraps past AR_ARRAY-1.

## Test plan
- Reset then idle:
  - ready=0 for exactly 64 cycles, then 1.
  - Reading addresses 0..63 on all 4 ports returns 0, with rd_valid pulsing 1 cycle after each rd_en.
- Dual retire to the same address: wr_en=2'b11, both ports to addr 5, data 0xAAAA0000 and 0x5555FFFF.
  - The next-cycle read of 5 returns 0x5555FFFF.
  - A write of 0x1234 to addr 0 reads back 0.
- Bypass:
  - BYPASS=1: write 0xDEADBEEF to addr 9 while port 2 reads addr 9 in the same cycle → rd_data[2]=0xDEADBEEF.
  - BYPASS=0 build, same stimulus → old value 0.
- clear_req in RUN with a concurrent write of 7 to addr 3:
  - ready drops next cycle and stays low 64 cycles.
  - A subsequent read of addr 3 returns 0.
  - rd_en/wr_en issued during the sweep give no rd_valid and no array change.
- Reset at sweep cycle 20: ready stays 0 for a further 64 cycles from the reset edge; clear_req pulsed mid-sweep does not extend it.
- Out-of-range address with AR_ARRAY=48, AR_SIZE=6: a write to 50 is dropped, and a read of 50 returns 0 with rd_valid=1.
